// File: rtl/echo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_pkg : command codes, FSM states and saturation helper for the         |
// |            multi-channel echo canceller.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package echo_pkg;

    localparam logic [7:0] CMD_RESET    = 8'h1F;
    localparam logic [7:0] CMD_DLY_INC  = 8'h11;
    localparam logic [7:0] CMD_DLY_DEC  = 8'h12;
    localparam logic [7:0] CMD_GAIN_INC = 8'h19;
    localparam logic [7:0] CMD_GAIN_DEC = 8'h1A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MUL  = 3'd2,
        ST_SUB  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Clamp a signed value into the range of a dw-bit two's-complement word.
    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_delay_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_delay_ram : simple dual-port delay memory, 1-cycle synchronous read,  |
// |                  read-before-write on address collision.                   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module echo_delay_ram
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16384,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/echo_canceller_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | echo_canceller_mc : y = x - ((y[n-D] * G) >>> 15) per channel, one shared  |
// |                     multiplier. Define ECHO_SAT_EN to saturate the result. |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module echo_canceller_mc
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int CH_NUM     = 2,
    parameter int MAX_DELAY  = 8192,
    parameter int DEF_DELAY  = 7996,
    parameter int DEF_GAIN   = 32767,
    parameter int GAIN_STEP  = 200
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic [CH_NUM*DATA_WIDTH-1:0]   data_in,
    input  logic                           cmd_valid,
    input  logic [7:0]                     cmd_code,
    output logic [CH_NUM*DATA_WIDTH-1:0]   data_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [$clog2(MAX_DELAY)-1:0]   delay_cur,
    output logic [COEF_WIDTH-1:0]          gain_cur
);

    localparam int PW    = $clog2(MAX_DELAY);
    localparam int CHW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int AW    = CHW + PW;
    localparam int FW    = PW + 1;
    localparam int SW    = DATA_WIDTH + 1;
    localparam int PRODW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int SHIFT = COEF_WIDTH - 1;
    localparam int FRW   = CH_NUM * DATA_WIDTH;

    localparam logic [PW-1:0]         DLY_DEF    = PW'(DEF_DELAY);
    localparam logic [PW-1:0]         DLY_MAX    = PW'(MAX_DELAY - 1);
    localparam logic [FW-1:0]         FILL_MAX   = FW'(MAX_DELAY);
    localparam logic [COEF_WIDTH-1:0] GAIN_DEF   = COEF_WIDTH'(DEF_GAIN);
    localparam logic [31:0]           GAIN_MAX_U = 32'((1 << (COEF_WIDTH - 1)) - 1);
    localparam logic [31:0]           STEP_U     = 32'(GAIN_STEP);

    state_t                  state_q, state_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic [FRW-1:0]          frame_q, frame_d;
    logic [FRW-1:0]          out_buf_q, out_buf_d;
    logic [FRW-1:0]          data_out_q, data_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [PW-1:0]           delay_q, delay_d;
    logic [COEF_WIDTH-1:0]   gain_q, gain_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic                    pend_v_q, pend_v_d;
    logic [7:0]              pend_code_q, pend_code_d;
    logic signed [PRODW-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic [DATA_WIDTH-1:0]        rd_data;
    logic signed [DATA_WIDTH-1:0] lane_x;
    logic signed [SW-1:0]         echo_term;
    logic signed [SW-1:0]         diff;
    logic                         echo_en;
    logic                         cmd_window;
    logic [7:0]                   cmd_sel;
    logic [31:0]                  gain_w;

    echo_delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CH_NUM * MAX_DELAY),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .we    (state_q == ST_WR),
        .waddr ({ch_q, wr_ptr_q}),
        .wdata (result_q),
        .raddr ({ch_q, PW'(wr_ptr_q - delay_q)}),
        .rdata (rd_data)
    );

    always_comb begin
        lane_x    = frame_q[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
        echo_term = SW'(prod_q >>> SHIFT);
        diff      = SW'(lane_x) - echo_term;
        // Until the line holds D frames the tap would point at unwritten RAM.
        echo_en   = ({1'b0, delay_q} <= fill_q);
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        frame_d     = frame_q;
        out_buf_d   = out_buf_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        delay_d     = delay_q;
        gain_d      = gain_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        prod_d      = prod_q;
        result_d    = result_q;
        cmd_window  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        cmd_sel     = cmd_valid ? cmd_code : pend_code_q;
        gain_w      = 32'(gain_q);

        if (sample_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    frame_d = data_in;
                    ch_d    = '0;
                    state_d = ST_RD;
                end
            end
            ST_RD: state_d = ST_MUL;
            ST_MUL: begin
                prod_d  = echo_en ? (PRODW'($signed(rd_data)) * PRODW'($signed({1'b0, gain_q})))
                                  : '0;
                state_d = ST_SUB;
            end
            ST_SUB: begin
`ifdef ECHO_SAT_EN
                result_d = DATA_WIDTH'(sat_dw(32'(diff), DATA_WIDTH));
`else
                result_d = DATA_WIDTH'(diff);
`endif
                state_d  = ST_WR;
            end
            ST_WR: begin
                out_buf_d[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH] = result_q;
                if (ch_q == CHW'(CH_NUM - 1)) begin
                    data_out_d  = out_buf_d;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FW'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Commands only take effect between frames; the newest one wins.
        if (cmd_window) begin
            if (cmd_valid || pend_v_q) begin
                pend_v_d = 1'b0;
                case (cmd_sel)
                    CMD_RESET: begin
                        delay_d = DLY_DEF;
                        gain_d  = GAIN_DEF;
                        fill_d  = '0;
                    end
                    CMD_DLY_INC: begin
                        if (delay_q < DLY_MAX) begin
                            delay_d = delay_q + PW'(1);
                        end
                        fill_d = '0;
                    end
                    CMD_DLY_DEC: begin
                        delay_d = (delay_q > PW'(1)) ? (delay_q - PW'(1)) : PW'(1);
                        fill_d  = '0;
                    end
                    CMD_GAIN_INC: begin
                        gain_d = ((gain_w + STEP_U) > GAIN_MAX_U) ? COEF_WIDTH'(GAIN_MAX_U)
                                                                   : COEF_WIDTH'(gain_w + STEP_U);
                    end
                    CMD_GAIN_DEC: begin
                        gain_d = (gain_w < STEP_U) ? '0 : COEF_WIDTH'(gain_w - STEP_U);
                    end
                    default: ;
                endcase
            end
        end else if (cmd_valid) begin
            pend_v_d    = 1'b1;
            pend_code_d = cmd_code;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            frame_q     <= '0;
            out_buf_q   <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            delay_q     <= DLY_DEF;
            gain_q      <= GAIN_DEF;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_code_q <= '0;
            prod_q      <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            frame_q     <= frame_d;
            out_buf_q   <= out_buf_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            delay_q     <= delay_d;
            gain_q      <= gain_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign delay_cur = delay_q;
    assign gain_cur  = gain_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_canceller_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_echo_canceller_mc : directed vectors for the multi-channel canceller,  |
// |                        using a shortened delay line (16 deep, D=12).      |
// | Revision             : 1.0                                                |
// +----------------------------------------------------------------------------+
module tb_echo_canceller_mc;

    localparam int DW = 16;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sample_valid;
    logic [CH*DW-1:0] data_in;
    logic            cmd_valid;
    logic [7:0]      cmd_code;
    logic [CH*DW-1:0] data_out;
    logic            out_valid;
    logic            busy;
    logic            overrun;
    logic [3:0]      delay_cur;
    logic [15:0]     gain_cur;

    int checks   = 0;
    int failures = 0;

`ifdef ECHO_SAT_EN
    localparam logic [15:0] SAT_E0 = 16'h8000;
    localparam logic [15:0] SAT_E1 = 16'h7FFF;
`else
    localparam logic [15:0] SAT_E0 = 16'h58E7;   // 22759
    localparam logic [15:0] SAT_E1 = 16'hA719;   // -22759
`endif

    echo_canceller_mc #(
        .DATA_WIDTH (16),
        .COEF_WIDTH (16),
        .CH_NUM     (CH),
        .MAX_DELAY  (16),
        .DEF_DELAY  (12),
        .DEF_GAIN   (32767),
        .GAIN_STEP  (200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .delay_cur    (delay_cur),
        .gain_cur     (gain_cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x0;
        logic [15:0] x1;
        logic        cv;
        logic [7:0]  cc;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t imp [13];

    function automatic logic [31:0] sx(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] x0, input logic [15:0] x1,
                             input logic cv, input logic [7:0] cc,
                             output logic [15:0] y0, output logic [15:0] y1);
        int n;
        sample_valid = 1'b1;
        data_in      = {x1, x0};
        cmd_valid    = cv;
        cmd_code     = cc;
        tick();
        sample_valid = 1'b0;
        cmd_valid    = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, 9);
        y0 = data_out[15:0];
        y1 = data_out[31:16];
        tick();
    endtask

    initial begin
        logic [15:0] y0, y1;
        int ov_cnt, ov_cyc;

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        data_in      = '0;
        cmd_valid    = 1'b0;
        cmd_code     = '0;
        tick();
        tick();
        check("rst_data_out", data_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_delay", delay_cur, 12);
        check("rst_gain", gain_cur, 32767);
        rst_n = 1'b1;
        tick();

        // Overrun/timing: frames offered on cycles 0 and 3.
        sample_valid = 1'b1;
        data_in      = {16'd100, 16'd100};
        ov_cnt = 0;
        ov_cyc = -1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            sample_valid = (c == 3);
            if (out_valid) begin
                ov_cnt++;
                if (ov_cyc < 0) ov_cyc = c;
            end
            if (c == 1)  check("busy_c1", busy, 1);
            if (c == 9)  check("busy_c9", busy, 1);
            if (c == 10) check("busy_c10", busy, 0);
        end
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_cycle", ov_cyc, 9);
        check("ovr_flag", overrun, 1);
        check("ovr_data0", sx(data_out[15:0]), 100);
        check("ovr_data1", sx(data_out[31:16]), 100);

        // Reset mid-frame.
        sample_valid = 1'b1;
        data_in      = {16'd555, 16'd555};
        tick();
        sample_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_data_out", data_out, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_delay", delay_cur, 12);
        check("mrst_gain", gain_cur, 32767);
        ov_cnt = 0;
        repeat (3) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        check("mrst_no_valid", ov_cnt, 0);
        check("mrst_idle", busy, 0);

        // Warm-up: echo muted for the first D frames.
        for (int f = 0; f < 13; f++) begin
            run_frame(16'd100, 16'd100, 1'b0, 8'h00, y0, y1);
            check($sformatf("warm_ch0_f%0d", f), sx(y0), (f < 12) ? 100 : 1);
            check($sformatf("warm_ch1_f%0d", f), sx(y1), (f < 12) ? 100 : 1);
        end

        // Commands.
        send_cmd(8'h1A); check("gain_dec", gain_cur, 32567);
        send_cmd(8'h19); check("gain_inc", gain_cur, 32767);
        send_cmd(8'h19); check("gain_inc_sat", gain_cur, 32767);
        send_cmd(8'h55); check("ign_delay", delay_cur, 12);
        check("ign_gain", gain_cur, 32767);
        repeat (5) send_cmd(8'h11);
        check("dly_inc_clamp", delay_cur, 15);

        // Mid-frame commands are held until DONE; the later one wins.
        sample_valid = 1'b1;
        data_in      = '0;
        tick();
        sample_valid = 1'b0;
        tick();
        send_cmd(8'h12);
        tick();
        send_cmd(8'h1A);
        tick();
        check("pend_hold_delay", delay_cur, 15);
        check("pend_hold_gain", gain_cur, 32767);
        repeat (3) tick();
        check("pend_done_valid", out_valid, 1);
        tick();
        check("pend_last_delay", delay_cur, 15);
        check("pend_last_gain", gain_cur, 32567);

        send_cmd(8'h1F);
        check("cmd_reset_delay", delay_cur, 12);
        check("cmd_reset_gain", gain_cur, 32767);
        repeat (200) send_cmd(8'h1A);
        check("gain_floor", gain_cur, 0);
        repeat (81) send_cmd(8'h19);
        check("gain_16200", gain_cur, 16200);
        repeat (8) send_cmd(8'h12);
        check("delay_4", delay_cur, 4);

        // Impulse, D=4; gain raised to 16400 by a command sharing frame 4's strobe.
        for (int i = 0; i < 13; i++) begin
            imp[i] = '{x0: 16'd0, x1: 16'd0, cv: 1'b0, cc: 8'h00, e0: 16'd0, e1: 16'd0};
        end
        imp[0].x0  = 16'd1000;
        imp[0].e0  = 16'd1000;
        imp[4].cv  = 1'b1;
        imp[4].cc  = 8'h19;
        imp[4].e0  = 16'hFE0C;   // -500
        imp[8].e0  = 16'd251;
        imp[12].e0 = 16'hFF83;   // -125
        for (int i = 0; i < 13; i++) begin
            run_frame(imp[i].x0, imp[i].x1, imp[i].cv, imp[i].cc, y0, y1);
            check($sformatf("imp_ch0_f%0d", i), sx(y0), sx(imp[i].e0));
            check($sformatf("imp_ch1_f%0d", i), sx(y1), sx(imp[i].e1));
        end
        check("imp_gain", gain_cur, 16400);

        // Delay clamps at 1, then a large result overflows both lanes.
        repeat (6) send_cmd(8'h12);
        check("dly_dec_clamp", delay_cur, 1);
        run_frame(16'd20000, 16'hB1E0, 1'b0, 8'h00, y0, y1);   // ch1 = -20000
        check("sat_pre_ch0", sx(y0), 20000);
        check("sat_pre_ch1", sx(y1), -20000);
        run_frame(16'h8000, 16'h7FFF, 1'b0, 8'h00, y0, y1);
        check("sat_ch0", sx(y0), sx(SAT_E0));
        check("sat_ch1", sx(y1), sx(SAT_E1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/echo_canceller_mc.md
Name: echo_canceller_mc

Overview:
- Multi-channel, parametrised successor to the single-channel echo canceller.
- Computes y[n] = x[n] − ((y[n−D] · G) >>> 15) per channel, where D is the delay and G is the gain.
- Uses a circular delay RAM and one time-multiplexed multiplier.
- Sits between the audio-in sample stream and the audio-out path, in the single system clock domain with a sample strobe.
- UART command bytes adjust D and G at runtime.

Parameters:
- DATA_WIDTH, 16: signed sample width.
- COEF_WIDTH, 16: unsigned gain width, Q1.15.
- CH_NUM, 2: number of channels, processed sequentially.
- MAX_DELAY, 8192: delay-line depth per channel; must be a power of two.
- DEF_DELAY, 7996: reset/default delay in samples.
- DEF_GAIN, 32767: reset/default gain.
- GAIN_STEP, 200: gain increment/decrement per command.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sample_valid, in, 1: one-cycle strobe; data_in holds one frame.
- data_in, in, CH_NUM*DATA_WIDTH: channel c occupies bits [c*DW +: DW].
- cmd_valid, in, 1: one-cycle strobe carrying a command byte.
- cmd_code, in, 8: command byte.
- data_out, out, CH_NUM*DATA_WIDTH: processed frame, registered.
- out_valid, out, 1: one-cycle strobe when data_out updates.
- busy, out, 1: high while a frame is in process.
- overrun, out, 1: sticky; set when sample_valid arrives while busy.
- delay_cur, out, log2(MAX_DELAY): current delay value.
- gain_cur, out, COEF_WIDTH: current gain value.

Behaviour:
- Reset values: data_out=0, out_valid=0, busy=0, overrun=0, delay_cur=DEF_DELAY, gain_cur=DEF_GAIN, wr_ptr=0, fill=0, FSM=IDLE.
- FSM states: IDLE → RD → MUL → SUB → WR → (next channel ? RD : DONE) → IDLE.
  - Advances one state per clock.
  - IDLE→RD only on sample_valid, which latches data_in into a frame register.
- Per-channel steps:
  - RD issues RAM read address {ch, wr_ptr − delay_cur} (mod MAX_DELAY).
  - MUL forms the product rd_data(signed) × gain(unsigned, zero-extended).
  - SUB computes diff = x − (prod >>> 15) at DW+1 bits.
  - WR writes the DW-bit result to {ch, wr_ptr} and to the data_out lane.
- DONE:
  - out_valid=1 for one cycle; all lanes update together.
  - wr_ptr increments with wrap at MAX_DELAY.
  - fill saturates at MAX_DELAY.
- Latency: sample_valid to out_valid = 4*CH_NUM + 1 cycles.
  - busy is high from the cycle after sample_valid through the DONE cycle.
- Warm-up: while fill < delay_cur, the echo term is forced to 0, so y = x. Unwritten RAM contents are never used.
- Overrun: a sample_valid while busy is dropped and sets overrun. Only rst_n clears overrun.
- Commands are accepted in any state but applied only in IDLE or DONE. A command arriving mid-frame is held in a one-entry pending register; a newer command overwrites it (last wins).
  - 0x1F: delay=DEF_DELAY, gain=DEF_GAIN, fill=0.
  - 0x11: delay+1, clamped to MAX_DELAY−1; fill=0.
  - 0x12: delay−1, clamped to 1; fill=0.
  - 0x19: gain+GAIN_STEP, saturating at 2^(COEF_WIDTH−1)−1.
  - 0x1A: gain−GAIN_STEP, saturating at 0.
  - Other codes are ignored.
- A delay change clears fill, which re-mutes the echo until the line refills. The RAM is not cleared.
- Simultaneous sample_valid and cmd_valid in IDLE: the command applies first, and the frame uses the new values.
- Asserting rst_n low mid-frame aborts the frame. No out_valid is issued; RAM contents are don't-care.

Optional Feature:
- Macro ECHO_SAT_EN.
  - Defined: diff saturates to [−2^(DW−1), 2^(DW−1)−1]. For DW=16 that is 0x8000/0x7FFF.
  - Undefined: diff is truncated to its low DW bits (two's-complement wrap), matching legacy behaviour.

Decomposition:
- Package echo_pkg holds:
  - Command code localparams: CMD_RESET, CMD_DLY_INC, CMD_DLY_DEC, CMD_GAIN_INC, CMD_GAIN_DEC.
  - FSM state enum.
  - Function sat_dw().
- Sub-module echo_delay_ram:
  - Simple dual-port, depth CH_NUM*MAX_DELAY, width DATA_WIDTH.
  - Synchronous read with 1-cycle latency; read-before-write on address collision.

Test Plan:
- Impulse: CH_NUM=2, gain=16384, delay=4.
  - Stimulus: ch0 gets 1000 on frame 0, zeros after.
  - Required response: ch0 outputs 1000, 0,0,0, −500, 0,0,0, 250, …; ch1 stays 0.
- Warm-up: delay=DEF_DELAY, constant x=100.
  - First 7996 frames output 100.
  - Frame 7996 outputs 100 − ((100·32767)>>>15) = 100 − 99 = 1.
- Commands:
  - 0x12 ×3 from delay=1 gives delay_cur=1.
  - 0x1A ×200 gives gain_cur=0.
  - 0x19 at 32700 gives 32767.
  - 0x1F restores 7996/32767.
- Saturation: x=−32768, echo term +X, ECHO_SAT_EN defined.
  - Output −32768.
  - With the macro undefined, output is the wrapped low 16 bits.
- Overrun/timing: sample_valid on cycles 0 and 3 with CH_NUM=2.
  - out_valid at cycle 9 only; overrun=1; second frame dropped.
- Reset mid-frame: rst_n low at cycle 5.
  - All outputs return to reset values; no out_valid.
  - Next frame after release behaves as in warm-up.
